// File: rtl/vga_color_sequencer.sv
// vga_color_sequencer: drives the colour and duty inputs of the VGA counter.
// Steps through an 8-entry palette, either every FRAMES_PER_STEP frames or
// on next/prev requests, and applies every change only on a frame boundary
// (vsync falling edge).
// Optional macro VGA_COLOR_FADE_EN: dutyValue fades as a triangle ramp
// between DUTY_MIN and DUTY_MAX. Without it dutyValue is fixed at
// DUTY_DEFAULT and no fade registers exist.
module vga_color_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned DUTY_DEFAULT    = 50,
  parameter int unsigned DUTY_MIN        = 10,
  parameter int unsigned DUTY_MAX        = 100,
  parameter int unsigned DUTY_STEP       = 5
) (
  input  logic        mhz_clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        auto_en,
  input  logic        hold,
  input  logic        next_req,
  input  logic        prev_req,
  output logic [3:0]  red_change,
  output logic [3:0]  green_change,
  output logic [3:0]  blue_change,
  output logic [26:0] dutyValue,
  output logic [2:0]  pal_idx,
  output logic        step_done
);

  localparam logic [7:0]  LAST_CNT = 8'(FRAMES_PER_STEP - 1);
  localparam logic [26:0] DUTY_RST = 27'(DUTY_DEFAULT);

  // Reject parameter sets the counter and ramp cannot represent.
  if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255 ||
      DUTY_MIN >= DUTY_MAX || DUTY_STEP == 0) begin : g_param_check
    $error("vga_color_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t      state, state_n;
  logic        vsync_q;
  logic        frame_tick;
  logic        pend_next, pend_prev;
  logic        pend_next_n, pend_prev_n;
  logic [2:0]  idx_n;
  logic [7:0]  frame_cnt, frame_cnt_n;
  logic        step_n;
  logic [11:0] rgb_n;

  // Palette entry as {red, green, blue}.
  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] rgb;
    unique case (idx)
      3'd0:    rgb = 12'h000;
      3'd1:    rgb = 12'hF00;
      3'd2:    rgb = 12'h0F0;
      3'd3:    rgb = 12'h00F;
      3'd4:    rgb = 12'hFF0;
      3'd5:    rgb = 12'h0FF;
      3'd6:    rgb = 12'hF0F;
      default: rgb = 12'hFFF;
    endcase
    return rgb;
  endfunction

  assign frame_tick = vsync_q & ~vsync;

  // State, pending flags, frame counter and registered outputs.
  always_ff @(posedge mhz_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      // Cleared so that vsync held low through reset does not fake a tick.
      vsync_q      <= 1'b0;
      pend_next    <= 1'b0;
      pend_prev    <= 1'b0;
      frame_cnt    <= '0;
      pal_idx      <= '0;
      step_done    <= 1'b0;
      red_change   <= '0;
      green_change <= '0;
      blue_change  <= '0;
    end else begin
      state        <= state_n;
      vsync_q      <= vsync;
      pend_next    <= pend_next_n;
      pend_prev    <= pend_prev_n;
      frame_cnt    <= frame_cnt_n;
      pal_idx      <= idx_n;
      step_done    <= step_n;
      red_change   <= rgb_n[11:8];
      green_change <= rgb_n[7:4];
      blue_change  <= rgb_n[3:0];
    end
  end

  // Next-state and frame-boundary update of index, counter and requests.
  always_comb begin
    state_n     = state;
    pend_next_n = pend_next | next_req;
    pend_prev_n = pend_prev | prev_req;
    idx_n       = pal_idx;
    frame_cnt_n = frame_cnt;
    step_n      = 1'b0;

    unique case (state)
      IDLE: begin
        // Requests seen before the first frame stay pending for RUN.
        if (frame_tick) begin
          state_n = RUN;
          idx_n   = '0;
          step_n  = 1'b1;
        end
      end
      RUN: begin
        if (hold) begin
          state_n = HOLD;
        end else if (frame_tick) begin
          // A pulse coincident with the tick belongs to the next frame.
          pend_next_n = next_req;
          pend_prev_n = prev_req;
          if (pend_next && !pend_prev) begin
            idx_n       = pal_idx + 3'd1;
            frame_cnt_n = '0;
            step_n      = 1'b1;
          end else if (pend_prev && !pend_next) begin
            idx_n       = pal_idx - 3'd1;
            frame_cnt_n = '0;
            step_n      = 1'b1;
          end else if (pend_next && pend_prev) begin
            // Opposing requests cancel: nothing moves this frame.
            idx_n = pal_idx;
          end else if (auto_en) begin
            if (frame_cnt == LAST_CNT) begin
              idx_n       = pal_idx + 3'd1;
              frame_cnt_n = '0;
              step_n      = 1'b1;
            end else begin
              frame_cnt_n = frame_cnt + 8'd1;
            end
          end
        end
      end
      HOLD: begin
        if (!hold) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase

    rgb_n = palette(idx_n);
  end

`ifdef VGA_COLOR_FADE_EN
  localparam logic [26:0] DUTY_LO = 27'(DUTY_MIN);
  localparam logic [26:0] DUTY_HI = 27'(DUTY_MAX);
  localparam logic [26:0] DUTY_INC = 27'(DUTY_STEP);

  logic [26:0] duty, duty_n;
  logic        dir_up, dir_up_n;

  // Fade register: duty value and ramp direction.
  always_ff @(posedge mhz_clk) begin
    if (!rst_n) begin
      duty   <= DUTY_RST;
      dir_up <= 1'b1;
    end else begin
      duty   <= duty_n;
      dir_up <= dir_up_n;
    end
  end

  // Triangle ramp, one step per frame while running.
  always_comb begin
    duty_n   = duty;
    dir_up_n = dir_up;
    if (state == RUN && !hold && frame_tick) begin
      if (dir_up) begin
        if (duty + DUTY_INC >= DUTY_HI) begin
          duty_n   = DUTY_HI;
          dir_up_n = 1'b0;
        end else begin
          duty_n = duty + DUTY_INC;
        end
      end else begin
        if (duty <= DUTY_LO + DUTY_INC) begin
          duty_n   = DUTY_LO;
          dir_up_n = 1'b1;
        end else begin
          duty_n = duty - DUTY_INC;
        end
      end
    end
  end

  assign dutyValue = duty;
`else
  assign dutyValue = DUTY_RST;
`endif

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Self-checking bench for vga_color_sequencer: frame-level reference model,
// randomized request placement and frame lengths.
module tb_vga_color_sequencer;

  localparam int unsigned FPS = 2;

  logic        mhz_clk = 1'b0;
  logic        rst_n, vsync, auto_en, hold, next_req, prev_req;
  logic [3:0]  red_change, green_change, blue_change;
  logic [26:0] dutyValue;
  logic [2:0]  pal_idx;
  logic        step_done;

  vga_color_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
    .mhz_clk(mhz_clk), .rst_n(rst_n), .vsync(vsync), .auto_en(auto_en),
    .hold(hold), .next_req(next_req), .prev_req(prev_req),
    .red_change(red_change), .green_change(green_change),
    .blue_change(blue_change), .dutyValue(dutyValue),
    .pal_idx(pal_idx), .step_done(step_done)
  );

  always #5 mhz_clk = ~mhz_clk;

  int checks = 0;
  int errors = 0;
  int sd_total = 0;

  // step_done pulses counted shortly after each rising edge.
  always @(posedge mhz_clk) begin
    #2;
    if (step_done === 1'b1) sd_total++;
  end

  logic [11:0] pal_tbl [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                               12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};

  // Frame-level reference model.
  bit m_started, m_pn, m_pp, m_up;
  int m_idx, m_cnt, m_duty;

  task automatic model_reset();
    m_started = 0; m_pn = 0; m_pp = 0; m_up = 1;
    m_idx = 0; m_cnt = 0; m_duty = 50;
  endtask

  task automatic model_tick(input bit au, input bit hd, output int exp_steps);
    exp_steps = 0;
    if (!m_started) begin
      m_started = 1; m_idx = 0; exp_steps = 1;
    end else if (!hd) begin
      if (m_pn || m_pp) begin
        if (m_pn != m_pp) begin
          m_idx = (m_idx + (m_pn ? 1 : 7)) % 8;
          m_cnt = 0;
          exp_steps = 1;
        end
        m_pn = 0; m_pp = 0;
      end else if (au) begin
        if (m_cnt + 1 >= FPS) begin
          m_idx = (m_idx + 1) % 8; m_cnt = 0; exp_steps = 1;
        end else m_cnt++;
      end
`ifdef VGA_COLOR_FADE_EN
      if (m_up) begin
        if (m_duty + 5 >= 100) begin m_duty = 100; m_up = 0; end
        else m_duty += 5;
      end else begin
        if (m_duty <= 15) begin m_duty = 10; m_up = 1; end
        else m_duty -= 5;
      end
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge mhz_clk);
    rst_n = 0; vsync = 1; auto_en = 0; hold = 0; next_req = 0; prev_req = 0;
    repeat (3) @(negedge mhz_clk);
    rst_n = 1;
    @(negedge mhz_clk);
    model_reset();
  endtask

  // Drives one frame: high phase with request pulses, then vsync low.
  task automatic run_frame(input int n_next, input int n_prev, input bit tick_next,
                           input bit au, input bit hd, output int steps_seen,
                           output int exp_steps, output logic [2:0] pre_idx,
                           output logic [11:0] pre_rgb);
    int sd0, high_len, base, k;
    sd0 = sd_total;
    auto_en = au; hold = hd;
    high_len = 10 + int'($urandom_range(0, 5));
    base = int'($urandom_range(0, 1));
    for (int c = 0; c < high_len; c++) begin
      k = c - 1 - base;
      next_req = (k >= 0) && (k % 2 == 0) && (k / 2 < n_next);
      prev_req = (k >= 0) && (k % 2 == 1) && (k / 2 < n_prev);
      @(negedge mhz_clk);
    end
    pre_idx = pal_idx;
    pre_rgb = {red_change, green_change, blue_change};
    vsync = 0; next_req = tick_next; prev_req = 0;
    @(negedge mhz_clk);
    next_req = 0;
    repeat (2) @(negedge mhz_clk);
    vsync = 1;
    @(negedge mhz_clk);
    steps_seen = sd_total - sd0;
    if (n_next > 0) m_pn = 1;
    if (n_prev > 0) m_pp = 1;
    model_tick(au, hd, exp_steps);
    if (tick_next) m_pn = 1;
  endtask

  task automatic test_reset();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    do_reset();
    checks++;
    if ({red_change, green_change, blue_change} !== 12'h000 || pal_idx !== 3'd0 ||
        step_done !== 1'b0 || dutyValue !== 27'd50) begin
      errors++;
      $display("FAIL reset_state rgb=%h idx=%0d sd=%b duty=%0d want 000/0/0/50",
               {red_change, green_change, blue_change}, pal_idx, step_done, dutyValue);
    end
    run_frame(0, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pr !== 12'h000) begin errors++; $display("FAIL reset_pre_rgb got %h want 000", pr); end
    checks++;
    if (pal_idx !== 3'd0 || s !== 1) begin
      errors++; $display("FAIL first_tick idx=%0d steps=%0d want 0/1", pal_idx, s);
    end
    checks++;
    if (dutyValue !== 27'(m_duty)) begin
      errors++; $display("FAIL first_duty got %0d want %0d", dutyValue, m_duty);
    end
  endtask

  task automatic test_auto();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    for (int f = 0; f < 16; f++) begin
      run_frame(0, 0, 0, 1, 0, s, e, pi, pr);
      checks++;
      if (pal_idx !== 3'(m_idx) || {red_change, green_change, blue_change} !== pal_tbl[m_idx]) begin
        errors++; $display("FAIL auto_idx f=%0d idx=%0d rgb=%h want %0d/%h", f, pal_idx,
                           {red_change, green_change, blue_change}, m_idx, pal_tbl[m_idx]);
      end
      checks++;
      if (s !== e) begin errors++; $display("FAIL auto_step f=%0d got %0d want %0d", f, s, e); end
      checks++;
      if (dutyValue !== 27'(m_duty)) begin
        errors++; $display("FAIL auto_duty f=%0d got %0d want %0d", f, dutyValue, m_duty);
      end
    end
  endtask

  task automatic test_manual();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    run_frame(0, 1, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pi !== 3'd0) begin errors++; $display("FAIL prev_pre got %0d want 0", pi); end
    checks++;
    if (pal_idx !== 3'd7 || {red_change, green_change, blue_change} !== 12'hFFF || s !== 1) begin
      errors++; $display("FAIL prev_wrap idx=%0d rgb=%h steps=%0d want 7/FFF/1", pal_idx,
                         {red_change, green_change, blue_change}, s);
    end
    run_frame(3, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== 3'd0 || s !== 1) begin
      errors++; $display("FAIL next_merge idx=%0d steps=%0d want 0/1", pal_idx, s);
    end
  endtask

  task automatic test_cancel();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    logic [2:0] start;
    start = pal_idx;
    run_frame(1, 1, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== start || s !== 0) begin
      errors++; $display("FAIL cancel idx=%0d steps=%0d want %0d/0", pal_idx, s, start);
    end
    run_frame(0, 0, 1, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== start || s !== 0) begin
      errors++; $display("FAIL tick_req_now idx=%0d steps=%0d want %0d/0", pal_idx, s, start);
    end
    run_frame(0, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== start + 3'd1 || s !== 1 || pal_idx !== 3'(m_idx)) begin
      errors++; $display("FAIL tick_req_next idx=%0d steps=%0d want %0d/1", pal_idx, s, m_idx);
    end
  endtask

  task automatic test_hold();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    logic [2:0] start; logic [26:0] duty0;
    start = pal_idx; duty0 = dutyValue;
    for (int f = 0; f < 3; f++) begin
      run_frame((f == 1) ? 1 : 0, 0, 0, 1, 1, s, e, pi, pr);
      checks++;
      if (pal_idx !== start || s !== 0 || dutyValue !== duty0) begin
        errors++; $display("FAIL hold_frozen f=%0d idx=%0d steps=%0d duty=%0d want %0d/0/%0d",
                           f, pal_idx, s, dutyValue, start, duty0);
      end
    end
    run_frame(0, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== start + 3'd1 || s !== 1 || dutyValue !== 27'(m_duty)) begin
      errors++; $display("FAIL hold_release idx=%0d steps=%0d duty=%0d want %0d/1/%0d",
                         pal_idx, s, dutyValue, m_idx, m_duty);
    end
  endtask

  task automatic test_random();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    int nn, np; bit tn, au, hd;
    for (int f = 0; f < 30; f++) begin
      nn = int'($urandom_range(0, 3));
      np = int'($urandom_range(0, 3));
      tn = ($urandom_range(0, 3) == 0);
      au = $urandom_range(0, 1) == 1;
      hd = ($urandom_range(0, 3) == 0);
      checks++;
      run_frame(nn, np, tn, au, hd, s, e, pi, pr);
      if (pal_idx !== 3'(m_idx) || {red_change, green_change, blue_change} !== pal_tbl[m_idx] ||
          s !== e || dutyValue !== 27'(m_duty)) begin
        errors++; $display("FAIL random f=%0d idx=%0d rgb=%h steps=%0d duty=%0d want %0d/%h/%0d/%0d",
                           f, pal_idx, {red_change, green_change, blue_change}, s, dutyValue,
                           m_idx, pal_tbl[m_idx], e, m_duty);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, e; logic [2:0] pi; logic [11:0] pr;
    @(negedge mhz_clk);
    next_req = 1;
    @(negedge mhz_clk);
    next_req = 0;
    do_reset();
    run_frame(0, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== 3'd0 || s !== 1) begin
      errors++; $display("FAIL rst_mid_first idx=%0d steps=%0d want 0/1", pal_idx, s);
    end
    run_frame(0, 0, 0, 0, 0, s, e, pi, pr);
    checks++;
    if (pal_idx !== 3'd0 || s !== 0 || dutyValue !== 27'(m_duty)) begin
      errors++; $display("FAIL rst_mid_discard idx=%0d steps=%0d duty=%0d want 0/0/%0d",
                         pal_idx, s, dutyValue, m_duty);
    end
  endtask

  initial begin
    rst_n = 0; vsync = 1; auto_en = 0; hold = 0; next_req = 0; prev_req = 0;
    test_reset();
    test_auto();
    test_manual();
    test_cancel();
    test_hold();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
